alu_md_seq: RTL

- Parametrised, sequential successor to the single-cycle ALU.
- Executes all base ALU operations (`ALU_* codes from define.v) plus the RV32M/RV64M multiply/divide group.
- Uses one shared shift-add multiplier and one restoring divider, with a valid/ready handshake on the input side and a one-cycle result pulse on the output side.
- Sits in the execute stage. The control unit holds issue while in_ready is low.

---
 rtl/alu_md_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_md_seq.sv
// alu_md_seq: sequential execute-stage ALU with RV32M/RV64M multiply/divide.
// Base ops and divide special cases finish in one cycle; multiply and divide
// run XLEN iterations on a single shared 2*XLEN accumulator.
module alu_md_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            md_en,
    input  logic [3:0]      alu_control,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;     // product / quotient sign
    logic              rneg_q, rneg_d;   // remainder sign
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;

    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   alu_res;
    logic              a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              b_zero, ovf, special;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN:0]     m_sum;
    logic [2*XLEN-1:0] mul_next, prod;
    logic [XLEN:0]     r_sh;
    logic [XLEN-1:0]   r_sub;
    logic              r_ge;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem, md_res;
    logic              res_we;

    assign shamt = B[SW-1:0];

    // Single-cycle base ALU; unknown codes pass A through.
    always_comb begin
        alu_res = A;
        case (alu_control)
            ALU_ADD:    alu_res = A + B;
            ALU_SUB:    alu_res = A - B;
            ALU_SLL:    alu_res = A << shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, A < B};
            ALU_XOR:    alu_res = A ^ B;
            ALU_SRL:    alu_res = A >> shamt;
            ALU_SRA:    alu_res = $signed(A) >>> shamt;
            ALU_OR:     alu_res = A | B;
            ALU_AND:    alu_res = A & B;
            ALU_COPY_B: alu_res = B;
            default:    alu_res = A;
        endcase
    end

    // Operand signedness, magnitudes and the divide special cases at accept.
    always_comb begin
        a_sgn    = md_op[2] ? !md_op[0] : (md_op[1:0] == 2'd1 || md_op[1:0] == 2'd2);
        b_sgn    = md_op[2] ? !md_op[0] : (md_op[1:0] == 2'd1);
        sa       = a_sgn & A[XLEN-1];
        sb       = b_sgn & B[XLEN-1];
        mag_a    = sa ? -A : A;
        mag_b    = sb ? -B : B;
        b_zero   = (B == '0);
        ovf      = !md_op[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        special  = md_op[2] && (b_zero || ovf);
        if (b_zero) spec_res = md_op[1] ? A : '1;
        else        spec_res = md_op[1] ? '0 : A;
    end

    // One shift-add multiply step and one restoring divide step per cycle.
    always_comb begin
        m_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {m_sum, acc_q[XLEN-1:1]};
        prod     = neg_q ? -mul_next : mul_next;
        r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        r_sub    = r_sh[XLEN-1:0] - b_q;
        r_ge     = (r_sh >= {1'b0, b_q});
        div_next = r_ge ? {r_sub, acc_q[XLEN-2:0], 1'b1}
                        : {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        quo      = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
        rem      = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        if (op_q[2])             md_res = op_q[1] ? rem : quo;
        else if (op_q[1:0] != 0) md_res = prod[2*XLEN-1:XLEN];
        else                     md_res = prod[XLEN-1:0];
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        b_d         = b_q;
        op_d        = op_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        res_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (!md_en || special) begin
                        result_d    = !md_en ? alu_res : spec_res;
                        res_we      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        b_d     = mag_b;
                        op_d    = md_op;
                        neg_d   = sa ^ sb;
                        rneg_d  = sa;
                        cnt_d   = CW'(XLEN);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        result_d    = md_res;
                        res_we      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = res_we ? (result_d == '0) : zero_q;
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
endmodule
